// File: rtl/kp_voice_alloc_if.sv
// Note-on / note-off request bundle between a note source and the voice allocator.
interface kp_voice_alloc_if;
   logic        note_valid;
   logic        note_ready;
   logic [6:0]  note_num;
   logic [6:0]  note_vel;
   logic [11:0] note_delay;
   logic        off_valid;
   logic [6:0]  off_num;

   modport master (output note_valid, note_num, note_vel, note_delay, off_valid, off_num,
                   input  note_ready);
   modport slave  (input  note_valid, note_num, note_vel, note_delay, off_valid, off_num,
                   output note_ready);
endinterface

// File: rtl/kp_voice_alloc.sv
// Allocates note-on requests to NV Karplus-Strong voices (retrigger, free, steal-oldest)
// and emits a per-voice trigger pulse with the voice's delay/velocity held stable.
//
// state | meaning
// IDLE  | note_ready high, waiting for a note-on handshake
// ALLOC | pick target voice from latched note
// LOAD  | write delay/vel/note into target voice, mark busy
// TRIG  | one settle cycle, then voice_trig high for TRIG_LEN cycles
module kp_voice_alloc #(
   parameter int NV       = 4,
   parameter int TRIG_LEN = 8,
   parameter int HOLD     = 4095
) (
   input  logic              audio_clk,
   input  logic              reset_n,
   kp_voice_alloc_if.slave   req_if,
   output logic [NV-1:0]     voice_trig,
   output logic [12*NV-1:0]  voice_delay,
   output logic [7*NV-1:0]   voice_vel,
   output logic [NV-1:0]     voice_busy
);
   localparam int IW = $clog2(NV);
   localparam int CW = $clog2(TRIG_LEN + 1);
   localparam logic [11:0]   HOLD_C = 12'(HOLD);
   localparam logic [CW-1:0] TRIG_C = CW'(TRIG_LEN);

   typedef enum logic [1:0] {IDLE, ALLOC, LOAD, TRIG} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] sel_q, sel_d;
   logic [6:0]    lat_num_q, lat_num_d;
   logic [6:0]    lat_vel_q, lat_vel_d;
   logic [11:0]   lat_delay_q, lat_delay_d;
   logic [11:0]   delay_q [NV];
   logic [11:0]   delay_d [NV];
   logic [6:0]    vel_q   [NV];
   logic [6:0]    vel_d   [NV];
   logic [6:0]    note_q  [NV];
   logic [6:0]    note_d  [NV];
   logic [11:0]   age_q   [NV];
   logic [11:0]   age_d   [NV];
   logic [NV-1:0] busy_q, busy_d;
   logic [NV-1:0] load_v;
   logic          hs;
   logic          hit, free;
   logic [IW-1:0] hit_idx, free_idx, old_idx;
   logic [11:0]   best_age;

   assign hs = req_if.note_valid && (state_q == IDLE);

   always_ff @(posedge audio_clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (hs) state_d = ALLOC;
         ALLOC:   state_d = LOAD;
         LOAD:    state_d = TRIG;
         TRIG:    if (cnt_q == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The first TRIG cycle (cnt at TRIG_C) is quiet so the new delay settles before the edge.
   always_comb begin
      req_if.note_ready = (state_q == IDLE);
      voice_trig        = '0;
      if (state_q == TRIG && cnt_q != TRIG_C) voice_trig[sel_q] = 1'b1;
   end

   always_comb begin
      hit      = 1'b0;
      free     = 1'b0;
      hit_idx  = '0;
      free_idx = '0;
      old_idx  = '0;
      best_age = age_q[0];
      for (int i = 0; i < NV; i++) begin
         if (!hit && busy_q[i] && note_q[i] == lat_num_q) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
         end
         if (!free && !busy_q[i]) begin
            free     = 1'b1;
            free_idx = IW'(i);
         end
         if (age_q[i] > best_age) begin
            best_age = age_q[i];
            old_idx  = IW'(i);
         end
      end
   end

   always_comb begin
      lat_num_d   = lat_num_q;
      lat_vel_d   = lat_vel_q;
      lat_delay_d = lat_delay_q;
      if (hs) begin
         lat_num_d   = req_if.note_num;
         lat_vel_d   = req_if.note_vel;
         lat_delay_d = req_if.note_delay;
      end
      sel_d = sel_q;
      if (state_q == ALLOC) sel_d = hit ? hit_idx : (free ? free_idx : old_idx);
      cnt_d = cnt_q;
      if (state_q == LOAD)                    cnt_d = TRIG_C;
      else if (state_q == TRIG && cnt_q != '0) cnt_d = cnt_q - 1'b1;
   end

   // LOAD has the final word over expiry and note-off on the same voice.
   always_comb begin
      busy_d = busy_q;
      load_v = '0;
      for (int i = 0; i < NV; i++) begin
         delay_d[i] = delay_q[i];
         vel_d[i]   = vel_q[i];
         note_d[i]  = note_q[i];
         age_d[i]   = age_q[i];
         load_v[i]  = (state_q == LOAD) && (sel_q == IW'(i));
         if (busy_q[i] && age_q[i] != 12'hFFF) age_d[i] = age_q[i] + 12'd1;
         if (busy_q[i] && age_q[i] == HOLD_C) busy_d[i] = 1'b0;
         if (req_if.off_valid && note_q[i] == req_if.off_num) busy_d[i] = 1'b0;
         if (load_v[i]) begin
            delay_d[i] = lat_delay_q;
            vel_d[i]   = lat_vel_q;
            note_d[i]  = lat_num_q;
            age_d[i]   = '0;
            busy_d[i]  = 1'b1;
         end
      end
   end

   always_ff @(posedge audio_clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q       <= '0;
         sel_q       <= '0;
         lat_num_q   <= '0;
         lat_vel_q   <= '0;
         lat_delay_q <= '0;
         busy_q      <= '0;
         for (int i = 0; i < NV; i++) begin
            delay_q[i] <= '0;
            vel_q[i]   <= '0;
            note_q[i]  <= '0;
            age_q[i]   <= '0;
         end
      end else begin
         cnt_q       <= cnt_d;
         sel_q       <= sel_d;
         lat_num_q   <= lat_num_d;
         lat_vel_q   <= lat_vel_d;
         lat_delay_q <= lat_delay_d;
         busy_q      <= busy_d;
         for (int i = 0; i < NV; i++) begin
            delay_q[i] <= delay_d[i];
            vel_q[i]   <= vel_d[i];
            note_q[i]  <= note_d[i];
            age_q[i]   <= age_d[i];
         end
      end
   end

   for (genvar g = 0; g < NV; g++) begin : g_flat
      assign voice_delay[12*g +: 12] = delay_q[g];
      assign voice_vel[7*g +: 7]     = vel_q[g];
   end
   assign voice_busy = busy_q;

endmodule

// File: tb/tb_kp_voice_alloc.sv
// Directed bench for kp_voice_alloc: dut_a uses the default HOLD, dut_b uses HOLD = 20.
module tb_kp_voice_alloc;
   localparam int NV = 4;

   logic audio_clk = 1'b0;
   always #5 audio_clk = ~audio_clk;

   logic        reset_n;
   logic        sel_dut;
   logic        n_valid;
   logic [6:0]  n_num, n_vel, o_num;
   logic [11:0] n_delay;
   logic        o_valid;

   kp_voice_alloc_if if_a ();
   kp_voice_alloc_if if_b ();

   assign if_a.note_valid = n_valid & ~sel_dut;
   assign if_b.note_valid = n_valid &  sel_dut;
   assign if_a.off_valid  = o_valid & ~sel_dut;
   assign if_b.off_valid  = o_valid &  sel_dut;
   assign if_a.note_num   = n_num;
   assign if_b.note_num   = n_num;
   assign if_a.note_vel   = n_vel;
   assign if_b.note_vel   = n_vel;
   assign if_a.note_delay = n_delay;
   assign if_b.note_delay = n_delay;
   assign if_a.off_num    = o_num;
   assign if_b.off_num    = o_num;

   logic [NV-1:0]    trig_a, trig_b, busy_a, busy_b;
   logic [12*NV-1:0] delay_a, delay_b;
   logic [7*NV-1:0]  vel_a, vel_b;

   kp_voice_alloc #(.NV(NV)) dut_a (
      .audio_clk(audio_clk), .reset_n(reset_n), .req_if(if_a),
      .voice_trig(trig_a), .voice_delay(delay_a), .voice_vel(vel_a), .voice_busy(busy_a));

   kp_voice_alloc #(.NV(NV), .HOLD(20)) dut_b (
      .audio_clk(audio_clk), .reset_n(reset_n), .req_if(if_b),
      .voice_trig(trig_b), .voice_delay(delay_b), .voice_vel(vel_b), .voice_busy(busy_b));

   logic [NV-1:0]    cur_trig, cur_busy;
   logic [12*NV-1:0] cur_delay;
   logic [7*NV-1:0]  cur_vel;
   logic             cur_ready;
   assign cur_trig  = sel_dut ? trig_b  : trig_a;
   assign cur_busy  = sel_dut ? busy_b  : busy_a;
   assign cur_delay = sel_dut ? delay_b : delay_a;
   assign cur_vel   = sel_dut ? vel_b   : vel_a;
   assign cur_ready = sel_dut ? if_b.note_ready : if_a.note_ready;

   int n_cmp = 0;
   int n_bad = 0;
   logic [NV-1:0] trig_seq  [0:24];
   logic [NV-1:0] busy_seq  [0:24];
   logic          ready_seq [0:24];

   task automatic do_reset();
      n_valid = 1'b0;
      o_valid = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge audio_clk);
      reset_n = 1'b1;
      @(negedge audio_clk);
   endtask

   // Returns just after the handshake edge (E0).
   task automatic send_note(input logic [6:0] num, input logic [6:0] vel,
                            input logic [11:0] dly, input bit keep);
      bit ok;
      ok = 1'b0;
      @(negedge audio_clk);
      n_num = num; n_vel = vel; n_delay = dly; n_valid = 1'b1;
      for (int k = 0; k < 40 && !ok; k++) begin
         if (cur_ready) begin
            @(posedge audio_clk);
            ok = 1'b1;
         end else begin
            @(negedge audio_clk);
         end
      end
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL handshake_timeout: note %0d not accepted within 40 cycles", num);
      end else if (!keep) begin
         #1 n_valid = 1'b0;
      end
   endtask

   // Sample j is taken on the falling edge after rising edge E(j).
   task automatic capture(input int n);
      for (int j = 0; j < n; j++) begin
         @(negedge audio_clk);
         trig_seq[j]  = cur_trig;
         busy_seq[j]  = cur_busy;
         ready_seq[j] = cur_ready;
      end
   endtask

   task automatic test_reset();
      sel_dut = 1'b0;
      do_reset();
      n_cmp++; if (cur_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", cur_ready); end
      n_cmp++; if (cur_trig !== 4'b0000) begin n_bad++; $display("FAIL reset_trig: got %b want 0000", cur_trig); end
      n_cmp++; if (cur_busy !== 4'b0000) begin n_bad++; $display("FAIL reset_busy: got %b want 0000", cur_busy); end
      n_cmp++; if (cur_delay !== '0) begin n_bad++; $display("FAIL reset_delay: got %h want 0", cur_delay); end
      n_cmp++; if (cur_vel !== '0) begin n_bad++; $display("FAIL reset_vel: got %h want 0", cur_vel); end
   endtask

   task automatic test_first_note();
      logic [NV-1:0] exp;
      sel_dut = 1'b0;
      do_reset();
      send_note(7'd60, 7'd100, 12'd400, 1'b0);
      capture(13);
      for (int j = 0; j < 13; j++) begin
         exp = (j >= 3 && j <= 10) ? 4'b0001 : 4'b0000;
         n_cmp++;
         if (trig_seq[j] !== exp) begin
            n_bad++; $display("FAIL first_trig[%0d]: got %b want %b", j, trig_seq[j], exp);
         end
      end
      n_cmp++; if (ready_seq[10] !== 1'b0) begin n_bad++; $display("FAIL first_ready_in_trig: got %b want 0", ready_seq[10]); end
      n_cmp++; if (ready_seq[11] !== 1'b1) begin n_bad++; $display("FAIL first_ready_after: got %b want 1", ready_seq[11]); end
      n_cmp++; if (busy_seq[2] !== 4'b0001) begin n_bad++; $display("FAIL first_busy: got %b want 0001", busy_seq[2]); end
      n_cmp++; if (cur_delay[11:0] !== 12'd400) begin n_bad++; $display("FAIL first_delay0: got %0d want 400", cur_delay[11:0]); end
      n_cmp++; if (cur_vel[6:0] !== 7'd100) begin n_bad++; $display("FAIL first_vel0: got %0d want 100", cur_vel[6:0]); end
   endtask

   task automatic test_back_to_back();
      logic [6:0]  notes [4];
      logic [11:0] dlys  [4];
      logic [NV-1:0] exp;
      notes = '{7'd60, 7'd62, 7'd64, 7'd67};
      dlys  = '{12'd400, 12'd380, 12'd360, 12'd340};
      sel_dut = 1'b0;
      do_reset();
      for (int v = 0; v < 4; v++) begin
         send_note(notes[v], 7'd80, dlys[v], 1'b0);
         capture(13);
         exp = 4'b0001 << v;
         n_cmp++;
         if (trig_seq[5] !== exp) begin n_bad++; $display("FAIL fill_trig[%0d]: got %b want %b", v, trig_seq[5], exp); end
         n_cmp++;
         if (cur_delay[12*v +: 12] !== dlys[v]) begin
            n_bad++; $display("FAIL fill_delay[%0d]: got %0d want %0d", v, cur_delay[12*v +: 12], dlys[v]);
         end
      end
      n_cmp++; if (cur_busy !== 4'b1111) begin n_bad++; $display("FAIL fill_busy: got %b want 1111", cur_busy); end
      send_note(7'd72, 7'd90, 12'd300, 1'b0);
      capture(13);
      n_cmp++; if (trig_seq[5] !== 4'b0001) begin n_bad++; $display("FAIL steal_trig: got %b want 0001", trig_seq[5]); end
      n_cmp++; if (cur_delay[11:0] !== 12'd300) begin n_bad++; $display("FAIL steal_delay0: got %0d want 300", cur_delay[11:0]); end
      n_cmp++; if (cur_delay[23:12] !== 12'd380) begin n_bad++; $display("FAIL steal_delay1: got %0d want 380", cur_delay[23:12]); end
   endtask

   task automatic test_retrigger();
      sel_dut = 1'b0;
      do_reset();
      send_note(7'd60, 7'd100, 12'd400, 1'b0);
      capture(13);
      send_note(7'd60, 7'd110, 12'd410, 1'b0);
      capture(13);
      n_cmp++; if (trig_seq[5] !== 4'b0001) begin n_bad++; $display("FAIL retrig_trig: got %b want 0001", trig_seq[5]); end
      n_cmp++; if (cur_busy !== 4'b0001) begin n_bad++; $display("FAIL retrig_busy: got %b want 0001", cur_busy); end
      n_cmp++; if (cur_delay[11:0] !== 12'd410) begin n_bad++; $display("FAIL retrig_delay0: got %0d want 410", cur_delay[11:0]); end
      n_cmp++; if (cur_delay[23:12] !== 12'd0) begin n_bad++; $display("FAIL retrig_delay1: got %0d want 0", cur_delay[23:12]); end
   endtask

   task automatic test_note_off();
      sel_dut = 1'b0;
      do_reset();
      send_note(7'd60, 7'd100, 12'd400, 1'b0);
      capture(13);
      send_note(7'd62, 7'd70, 12'd380, 1'b0);
      capture(13);
      o_num = 7'd60; o_valid = 1'b1;
      n_cmp++; if (cur_busy !== 4'b0011) begin n_bad++; $display("FAIL off_busy_before: got %b want 0011", cur_busy); end
      @(negedge audio_clk);
      o_valid = 1'b0;
      n_cmp++; if (cur_busy !== 4'b0010) begin n_bad++; $display("FAIL off_busy_after: got %b want 0010", cur_busy); end
      n_cmp++; if (cur_delay[11:0] !== 12'd400) begin n_bad++; $display("FAIL off_delay_kept: got %0d want 400", cur_delay[11:0]); end
      n_cmp++; if (cur_vel[6:0] !== 7'd100) begin n_bad++; $display("FAIL off_vel_kept: got %0d want 100", cur_vel[6:0]); end
      send_note(7'd64, 7'd50, 12'd500, 1'b0);
      capture(13);
      n_cmp++; if (trig_seq[5] !== 4'b0001) begin n_bad++; $display("FAIL off_reuse_trig: got %b want 0001", trig_seq[5]); end
      n_cmp++; if (cur_delay[11:0] !== 12'd500) begin n_bad++; $display("FAIL off_reuse_delay: got %0d want 500", cur_delay[11:0]); end
   endtask

   task automatic test_off_during_trig();
      send_note(7'd66, 7'd40, 12'd700, 1'b0);
      for (int j = 0; j < 13; j++) begin
         @(negedge audio_clk);
         trig_seq[j] = cur_trig;
         busy_seq[j] = cur_busy;
         if (j == 4) begin o_num = 7'd66; o_valid = 1'b1; end
         if (j == 5) o_valid = 1'b0;
      end
      n_cmp++; if (busy_seq[4] !== 4'b0111) begin n_bad++; $display("FAIL offtrig_busy_pre: got %b want 0111", busy_seq[4]); end
      n_cmp++; if (busy_seq[5] !== 4'b0011) begin n_bad++; $display("FAIL offtrig_busy_post: got %b want 0011", busy_seq[5]); end
      n_cmp++; if (trig_seq[10] !== 4'b0100) begin n_bad++; $display("FAIL offtrig_last: got %b want 0100", trig_seq[10]); end
      n_cmp++; if (trig_seq[11] !== 4'b0000) begin n_bad++; $display("FAIL offtrig_end: got %b want 0000", trig_seq[11]); end
   endtask

   task automatic test_hold();
      logic exp_b, exp_r;
      sel_dut = 1'b1;
      do_reset();
      send_note(7'd50, 7'd90, 12'd100, 1'b1);
      for (int j = 0; j < 25; j++) begin
         @(negedge audio_clk);
         busy_seq[j]  = cur_busy;
         ready_seq[j] = cur_ready;
         if (j == 11) n_valid = 1'b0;
      end
      for (int j = 0; j < 25; j++) begin
         exp_b = (j >= 2 && j <= 22);
         exp_r = (j >= 11);
         n_cmp++;
         if (busy_seq[j][0] !== exp_b) begin
            n_bad++; $display("FAIL hold_busy[%0d]: got %b want %b", j, busy_seq[j][0], exp_b);
         end
         n_cmp++;
         if (ready_seq[j] !== exp_r) begin
            n_bad++; $display("FAIL hold_ready[%0d]: got %b want %b", j, ready_seq[j], exp_r);
         end
      end
      sel_dut = 1'b0;
   endtask

   task automatic test_reset_mid_trig();
      sel_dut = 1'b0;
      do_reset();
      send_note(7'd60, 7'd100, 12'd400, 1'b0);
      repeat (7) @(negedge audio_clk);
      n_cmp++; if (cur_trig !== 4'b0001) begin n_bad++; $display("FAIL midrst_trig_pre: got %b want 0001", cur_trig); end
      reset_n = 1'b0;
      #1;
      n_cmp++; if (cur_trig !== 4'b0000) begin n_bad++; $display("FAIL midrst_trig: got %b want 0000", cur_trig); end
      n_cmp++; if (cur_busy !== 4'b0000) begin n_bad++; $display("FAIL midrst_busy: got %b want 0000", cur_busy); end
      n_cmp++; if (cur_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b want 1", cur_ready); end
      @(negedge audio_clk);
      reset_n = 1'b1;
      send_note(7'd62, 7'd20, 12'd222, 1'b0);
      capture(13);
      n_cmp++; if (trig_seq[3] !== 4'b0001) begin n_bad++; $display("FAIL midrst_next_trig: got %b want 0001", trig_seq[3]); end
      n_cmp++; if (cur_delay[11:0] !== 12'd222) begin n_bad++; $display("FAIL midrst_next_delay: got %0d want 222", cur_delay[11:0]); end
      n_cmp++; if (cur_busy !== 4'b0001) begin n_bad++; $display("FAIL midrst_next_busy: got %b want 0001", cur_busy); end
   endtask

   initial begin
      reset_n = 1'b0;
      sel_dut = 1'b0;
      n_valid = 1'b0;
      o_valid = 1'b0;
      n_num   = '0;
      n_vel   = '0;
      n_delay = '0;
      o_num   = '0;
      test_reset();
      test_first_note();
      test_back_to_back();
      test_retrigger();
      test_note_off();
      test_off_during_trig();
      test_hold();
      test_reset_mid_trig();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/kp_voice_alloc.md
KP_VOICE_ALLOC -- requirements
Module: kp_voice_alloc

Interface
REQ-001 Parameter: NV, default 4, number of KP string voices driven (2..8).
REQ-002 Parameter: TRIG_LEN, default 8, voice trigger pulse width in audio_clk cycles (≥5 so the voice's trigger debounce accepts it).
REQ-003 Parameter: HOLD, default 4095, busy lifetime of a voice in audio_clk cycles (1..4095).
REQ-004 audio_clk  in  1  sole clock, 96 kHz sample clock; all logic on its rising edge.
REQ-005 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 note_valid  in  1  note-on request pending.
REQ-007 note_ready  out  1  note-on accepted when note_valid & note_ready at a rising edge.
REQ-008 note_num  in  7  MIDI note number of the request.
REQ-009 note_vel  in  7  velocity of the request.
REQ-010 note_delay  in  12  delay length (tuning) for the request.
REQ-011 off_valid  in  1  single-cycle note-off strobe, always accepted.
REQ-012 off_num  in  7  note number to release.
REQ-013 voice_trig  out  NV  per-voice active-high trigger pulse.
REQ-014 voice_delay  out  12*NV  per-voice delay length, voice i at bits [12i+11:12i].
REQ-015 voice_vel  out  7*NV  per-voice velocity, voice i at bits [7i+6:7i].
REQ-016 voice_busy  out  NV  per-voice busy flag.

Function
REQ-017 FSM states: IDLE, ALLOC, LOAD, TRIG; note_ready = 1 only in IDLE.
REQ-018 IDLE: on handshake latch note_num/note_vel/note_delay, go to ALLOC; otherwise stay.
REQ-019 ALLOC (1 cycle) selects voice v in priority: (a) busy voice whose stored note equals latched note (retrigger); (b) lowest-index non-busy voice; (c) busy voice with largest age, tie to lowest index (steal); then go to LOAD.
REQ-020 LOAD (1 cycle): write voice_delay[v], voice_vel[v], stored note[v]; clear age[v]; set voice_busy[v]; go to TRIG.
REQ-021 TRIG: assert voice_trig[v] for exactly TRIG_LEN consecutive cycles, then return to IDLE; voice_delay[v] is stable from the cycle before trig rises until the next LOAD of v.
REQ-022 At most one voice_trig bit is high at any time; request-to-trig-rise latency is 3 cycles after the handshake edge.
REQ-023 Age: per-voice 12-bit counter; increments each cycle while busy and the voice is not in LOAD; when age reaches HOLD, busy clears the following cycle; age saturates at 4095.
REQ-024 Note-off: in any state, off_valid clears busy of every voice whose stored note equals off_num; stored delay/vel/note are retained.
REQ-025 Note-off and LOAD on the same voice in the same cycle: LOAD wins (busy = 1).
REQ-026 Note-off during TRIG for the triggering voice clears busy but does not shorten voice_trig.
REQ-027 Non-busy voices keep voice_delay/voice_vel unchanged; outputs change only in LOAD.
REQ-028 note_valid while not in IDLE is held off (note_ready = 0); no request is dropped or duplicated.

Reset
REQ-029 reset_n low asynchronously forces: FSM = IDLE, note_ready = 1 once the FSM is in IDLE, voice_trig = 0, voice_busy = 0, all ages = 0, voice_delay = 0, voice_vel = 0, stored notes = 0.
REQ-030 Reset mid-TRIG terminates the pulse immediately; the first note after reset release is handled as on a fresh start.

Verification
REQ-031 After reset, note (60, vel 100, delay 400) -> voice 0 loaded, voice_delay[0] = 400, voice_trig = 0001 for 8 cycles starting 3 cycles after handshake, busy = 0001.
REQ-032 Four distinct notes back-to-back, then a fifth (72) -> voices 0..3 filled in order; the fifth steals voice 0 (oldest) and voice_delay[0] takes the new delay.
REQ-033 Note 60 on voice 0, then note 60 again while voices 1..3 are free -> voice 0 retriggered, voice 1 untouched.
REQ-034 Note 60 on voice 0, off_valid with off_num = 60 -> busy[0] clears next cycle; the next note goes to voice 0.
REQ-035 HOLD = 20, single note, no off -> busy[0] clears 21 cycles after LOAD; note_valid held high during TRIG -> note_ready stays 0 until TRIG ends.
REQ-036 reset_n pulsed low during TRIG cycle 4 -> voice_trig = 0 and voice_busy = 0 immediately; following note loads voice 0.
